// File: rtl/rx_spart_if.sv
// Host-side register bus of the SPART receiver: read strobe decode inputs
// plus the received byte and its status flags.
interface rx_spart_if;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] rx_data;
    logic       rda;
    logic       ferr;
    logic       ovr;

    modport master (
        output iorw,
        output ioaddr,
        input  rx_data,
        input  rda,
        input  ferr,
        input  ovr
    );

    modport slave (
        input  iorw,
        input  ioaddr,
        output rx_data,
        output rda,
        output ferr,
        output ovr
    );
endinterface

// File: rtl/rx_spart.sv
// 8N1 serial receiver with oversampled bit timing, a host-visible data
// register and sticky available / framing / overrun status.

module rx_spart_chk #(
    parameter int OVERSAMPLE = 16,
    parameter int TW         = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          rda,
    input logic          ovr,
    input logic          in_idle,
    input logic [TW-1:0] tick_cnt,
    input logic [2:0]    bit_cnt
);
    // Overrun can only exist alongside unread data.
    a_ovr_needs_rda: assert property (@(posedge clk) disable iff (rst) !rda |-> !ovr);

    // Tick counter never leaves its bit-period range.
    a_tick_range: assert property (@(posedge clk) disable iff (rst)
        tick_cnt <= TW'(OVERSAMPLE - 1));

    // Counters are parked at zero whenever the line is idle.
    a_idle_clear: assert property (@(posedge clk) disable iff (rst)
        in_idle |-> (tick_cnt == TW'(0) && bit_cnt == 3'd0));
endmodule

module rx_spart #(
    parameter int OVERSAMPLE = 16
) (
    input logic       clk,
    input logic       rst,
    input logic       rxd,
    input logic       brg_tick,
    rx_spart_if.slave bus
);
    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [TW-1:0] tick_r;
    logic [TW-1:0] tick_nxt_s;
    logic [2:0]    bit_r;
    logic [2:0]    bit_nxt_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_nxt_s;
    logic          sync_r;
    logic          rxs_r;
    logic          done_s;
    logic          rd_stb_s;
    logic [7:0]    rx_data_r;
    logic          rda_r;
    logic          ferr_r;
    logic          ovr_r;

    assign rd_stb_s    = (bus.ioaddr == 2'b00) && bus.iorw;
    assign bus.rx_data = rx_data_r;
    assign bus.rda     = rda_r;
    assign bus.ferr    = ferr_r;
    assign bus.ovr     = ovr_r;

    // Two-flop synchronizer; resets to the idle (mark) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 1'b1;
            rxs_r  <= 1'b1;
        end else begin
            sync_r <= rxd;
            rxs_r  <= sync_r;
        end
    end

    // Receiver state, counters and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            tick_r  <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            tick_r  <= tick_nxt_s;
            bit_r   <= bit_nxt_s;
            shift_r <= shift_nxt_s;
        end
    end

    // Next-state logic; counters only move on brg_tick once a frame has begun.
    always_comb begin
        state_nxt_s = state_r;
        tick_nxt_s  = tick_r;
        bit_nxt_s   = bit_r;
        shift_nxt_s = shift_r;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                tick_nxt_s = '0;
                bit_nxt_s  = 3'd0;
                if (!rxs_r) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (brg_tick) begin
                    if (tick_r == TICK_HALF) begin
                        // Mid start bit: a line that is high again was a glitch.
                        tick_nxt_s  = '0;
                        bit_nxt_s   = 3'd0;
                        state_nxt_s = rxs_r ? IDLE : DATA;
                    end else begin
                        tick_nxt_s = tick_r + TW'(1);
                    end
                end else begin
                    tick_nxt_s = tick_r;
                end
            end
            DATA: begin
                if (brg_tick) begin
                    if (tick_r == TICK_LAST) begin
                        tick_nxt_s  = '0;
                        shift_nxt_s = {rxs_r, shift_r[7:1]};
                        if (bit_r == 3'd7) begin
                            bit_nxt_s   = 3'd0;
                            state_nxt_s = STOP;
                        end else begin
                            bit_nxt_s = bit_r + 3'd1;
                        end
                    end else begin
                        tick_nxt_s = tick_r + TW'(1);
                    end
                end else begin
                    tick_nxt_s = tick_r;
                end
            end
            STOP: begin
                if (brg_tick) begin
                    if (tick_r == TICK_LAST) begin
                        tick_nxt_s  = '0;
                        done_s      = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        tick_nxt_s = tick_r + TW'(1);
                    end
                end else begin
                    tick_nxt_s = tick_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                tick_nxt_s  = '0;
                bit_nxt_s   = 3'd0;
            end
        endcase
    end

    // Host registers; a completing frame takes priority over a read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_r <= 8'h00;
            rda_r     <= 1'b0;
            ferr_r    <= 1'b0;
            ovr_r     <= 1'b0;
        end else if (done_s) begin
            rx_data_r <= shift_r;
            rda_r     <= 1'b1;
            ferr_r    <= ~rxs_r;
            ovr_r     <= rda_r & ~rd_stb_s;
        end else if (rd_stb_s) begin
            rda_r <= 1'b0;
            ovr_r <= 1'b0;
        end else begin
            rda_r <= rda_r;
            ovr_r <= ovr_r;
        end
    end

    rx_spart_chk #(
        .OVERSAMPLE(OVERSAMPLE),
        .TW        (TW)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .rda     (rda_r),
        .ovr     (ovr_r),
        .in_idle (state_r == IDLE),
        .tick_cnt(tick_r),
        .bit_cnt (bit_r)
    );
endmodule

// File: tb/tb_rx_spart.sv
// Directed plus randomized frames for rx_spart, checked against a flag model
// updated from the receiver's documented rules.
module tb_rx_spart;
    localparam int OS  = 16;
    localparam int DIV = 3;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic rxd      = 1'b1;
    logic brg_tick = 1'b0;
    int   gen_cnt  = 0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_data = 8'h00;
    logic       m_rda  = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;

    rx_spart_if bus ();

    rx_spart #(.OVERSAMPLE(OS)) dut (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .brg_tick(brg_tick),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Baud tick: one clock wide, every DIV clocks, changing 2ns after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            gen_cnt  = (gen_cnt + 1) % DIV;
            brg_tick = (gen_cnt == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rx_data"}, bus.rx_data, m_data);
        chk({tag, ".rda"}, {7'd0, bus.rda}, {7'd0, m_rda});
        chk({tag, ".ferr"}, {7'd0, bus.ferr}, {7'd0, m_ferr});
        chk({tag, ".ovr"}, {7'd0, bus.ovr}, {7'd0, m_ovr});
    endtask

    // Returns at the falling edge following the n-th tick.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (brg_tick !== 1'b1);
            @(negedge clk);
        end
    endtask

    // Drives one frame starting right after a tick. The stop bit is sampled
    // on the 153rd tick from the start-bit edge (2 sync flops, 1 idle cycle,
    // then OS/2 + 8*OS + OS counted ticks).
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic collide);
        rxd = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_ticks(OS);
        end
        rxd = stop_ok;
        wait_ticks(8);
        for (int i = 0; i < 8 && brg_tick !== 1'b1; i++) @(negedge clk);
        if (collide) begin
            bus.ioaddr = 2'b00;
            bus.iorw   = 1'b1;
        end
        chk("latency.rda_before", {7'd0, bus.rda}, {7'd0, m_rda});
        @(negedge clk);
        bus.iorw = 1'b0;
        m_ovr  = collide ? 1'b0 : (m_ovr | m_rda);
        m_rda  = 1'b1;
        m_data = d;
        m_ferr = ~stop_ok;
        check_all(collide ? "collide" : "frame");
        wait_ticks(7);
        rxd = 1'b1;
    endtask

    task automatic do_read();
        bus.ioaddr = 2'b00;
        bus.iorw   = 1'b1;
        @(negedge clk);
        bus.iorw = 1'b0;
        m_rda = 1'b0;
        m_ovr = 1'b0;
        check_all("read");
    endtask

    initial begin
        logic [7:0] rnd_d;
        logic       rnd_ok;
        logic       prev_ok;

        bus.iorw   = 1'b0;
        bus.ioaddr = 2'b00;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Single frame, then accesses that are not reads, then a read.
        wait_ticks(2);
        send_frame(8'hA5, 1'b1, 1'b0);
        bus.ioaddr = 2'b01;
        bus.iorw   = 1'b1;
        @(negedge clk);
        bus.ioaddr = 2'b00;
        bus.iorw   = 1'b0;
        @(negedge clk);
        check_all("no_read_access");
        do_read();

        // Glitch shorter than half a bit.
        wait_ticks(1);
        rxd = 1'b0;
        wait_ticks(3);
        rxd = 1'b1;
        wait_ticks(12);
        check_all("glitch");
        send_frame(8'h3C, 1'b1, 1'b0);
        do_read();

        // Framing error, then a good frame clears ferr (unread -> overrun).
        wait_ticks(1);
        send_frame(8'h0F, 1'b0, 1'b0);
        wait_ticks(12);
        send_frame(8'h5A, 1'b1, 1'b0);
        do_read();

        // Overrun.
        wait_ticks(1);
        send_frame(8'h11, 1'b1, 1'b0);
        wait_ticks(1);
        send_frame(8'h22, 1'b1, 1'b0);
        do_read();

        // Read strobe on the completion edge of the second byte.
        wait_ticks(1);
        send_frame(8'h44, 1'b1, 1'b0);
        wait_ticks(1);
        send_frame(8'h55, 1'b1, 1'b1);

        // Reset in the middle of bit 4 of 8'hFF.
        wait_ticks(1);
        rxd = 1'b0;
        wait_ticks(OS);
        rxd = 1'b1;
        wait_ticks(OS * 4 + OS / 2);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        m_data = 8'h00;
        m_rda  = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check_all("mid_reset");
        wait_ticks(OS * 5);
        check_all("after_reset_idle");
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        do_read();

        // Random frames, stop bits and reads.
        prev_ok = 1'b1;
        for (int k = 0; k < 12; k++) begin
            rnd_d  = 8'($urandom);
            rnd_ok = ($urandom_range(0, 3) != 0);
            wait_ticks(prev_ok ? int'($urandom_range(1, 3)) : 12);
            send_frame(rnd_d, rnd_ok, 1'b0);
            if ($urandom_range(0, 1) == 1) do_read();
            prev_ok = rnd_ok;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
